// File: rtl/adder_share_arb_if.sv
// Bundle of requester, shared-adder and response signals for adder_share_arb.
// The arbiter connects through the slave modport and its environment through master.
interface adder_share_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  // Requester side
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  // Shared adder side
  logic [3:0]           add_a;
  logic [3:0]           add_b;
  logic                 add_cin;
  logic [3:0]           add_sum;
  logic                 add_carry;
  // Response side
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [3:0]           rsp_sum;
  logic                 rsp_carry;
  // Status
  logic                 busy;
  logic                 err;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, add_carry, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy, err
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, add_carry, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy, err
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one external 4-bit adder among NUM_REQ requesters.
// IDLE grants and latches operands, EXEC lets the adder settle and captures the
// result, RESP holds the tagged result until the consumer accepts it.
module adder_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  adder_share_arb_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [3:0]      add_a_q, add_a_d;
  logic [3:0]      add_b_q, add_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [3:0]      rsp_sum_q, rsp_sum_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic            err_q, err_d;

  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic [4:0]      exp_sum;

  // Round-robin search: first valid requester at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Reference sum used to cross-check the external adder.
  assign exp_sum = {1'b0, add_a_q} + {1'b0, add_b_q};

  // Next-state and register updates for the three-state sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          add_a_d  = bus.req_a[{win, 2'b00} +: 4];
          add_b_d  = bus.req_b[{win, 2'b00} +: 4];
          rsp_id_d = win;
          state_d  = StExec;
        end
      end
      StExec: begin
        rsp_sum_d   = bus.add_sum;
        rsp_carry_d = bus.add_carry;
        rsp_valid_d = 1'b1;
        if ({bus.add_carry, bus.add_sum} != exp_sum) begin
          err_d = 1'b1;
        end
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset taking priority over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      err_q       <= err_d;
    end
  end

  // Grant pulse is combinational in IDLE; masked by rst so reset wins over a grant.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == StIdle && found && !rst) begin
      bus.req_ready = NUM_REQ'(1) << win;
    end
  end

  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = 1'b0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb with a behavioural 4-bit adder that
// can be made to return a+b+1 to exercise the mismatch flag.
module tb_adder_share_arb;

  localparam int unsigned NUM_REQ = 4;

  logic clk;
  logic rst;
  logic fault;
  int   total;
  int   bad;
  int   cyc_cnt;

  adder_share_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  adder_share_arb #(.NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared adder model, optionally off by one.
  assign {bus.add_carry, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       carry;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full transaction from a single requester with rsp_ready held high.
  task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] sum, input logic carry, input logic err_exp);
    bus.rsp_ready = 1'b1;
    bus.req_a[id*4 +: 4] = a;
    bus.req_b[id*4 +: 4] = b;
    bus.req_valid = 4'(1 << id);
    #1;
    chk("grant", 32'(bus.req_ready), 32'(1 << id));
    tick();
    bus.req_valid = '0;
    chk("exec_busy", 32'(bus.busy), 32'd1);
    chk("exec_ready0", 32'(bus.req_ready), 32'd0);
    chk("add_a", 32'(bus.add_a), 32'(a));
    chk("add_b", 32'(bus.add_b), 32'(b));
    chk("exec_valid0", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(id));
    chk("rsp_sum", 32'(bus.rsp_sum), 32'(sum));
    chk("rsp_carry", 32'(bus.rsp_carry), 32'(carry));
    chk("err", 32'(bus.err), 32'(err_exp));
    chk("add_cin", 32'(bus.add_cin), 32'd0);
    tick();
    chk("idle_valid0", 32'(bus.rsp_valid), 32'd0);
    chk("idle_busy0", 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_add_a"}, 32'(bus.add_a), 32'd0);
    chk({tag, "_add_b"}, 32'(bus.add_b), 32'd0);
    chk({tag, "_cin"}, 32'(bus.add_cin), 32'd0);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_sum"}, 32'(bus.rsp_sum), 32'd0);
    chk({tag, "_carry"}, 32'(bus.rsp_carry), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    int n;
    int prev;
    total = 0;
    bad   = 0;
    cyc_cnt = 0;
    fault = 1'b0;
    rst   = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    vecs[0] = '{id: 2, a: 4'd9,  b: 4'd5,  sum: 4'd14, carry: 1'b0};
    vecs[1] = '{id: 0, a: 4'd15, b: 4'd15, sum: 4'd14, carry: 1'b1};
    vecs[2] = '{id: 1, a: 4'd0,  b: 4'd0,  sum: 4'd0,  carry: 1'b0};
    vecs[3] = '{id: 3, a: 4'd8,  b: 4'd8,  sum: 4'd0,  carry: 1'b1};
    vecs[4] = '{id: 2, a: 4'd7,  b: 4'd9,  sum: 4'd0,  carry: 1'b1};
    vecs[5] = '{id: 1, a: 4'd10, b: 4'd3,  sum: 4'd13, carry: 1'b0};

    tick();
    tick();
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].carry, 1'b0);
    end

    // Fairness: reset puts ptr at 0, all requesters valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*4 +: 4] = 4'(i + 1);
      bus.req_b[i*4 +: 4] = 4'(2 * i + 3);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    prev = 0;
    for (int k = 0; k < 12; k++) begin
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 8) begin
        tick();
        n++;
      end
      chk("fair_rsp_seen", 32'(bus.rsp_valid), 32'd1);
      chk("fair_id", 32'(bus.rsp_id), 32'(k % 4));
      chk("fair_sum", 32'(bus.rsp_sum), 32'(3 * (k % 4) + 4));
      if (k > 0) chk("fair_period", 32'(cyc_cnt - prev), 32'd3);
      prev = cyc_cnt;
      tick();
    end
    bus.req_valid = '0;
    tick();

    // Backpressure: requester 1, others shouting during RESP
    bus.rsp_ready = 1'b0;
    bus.req_a[7:4] = 4'd6;
    bus.req_b[7:4] = 4'd7;
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_sum", 32'(bus.rsp_sum), 32'd13);
      chk("bp_carry", 32'(bus.rsp_carry), 32'd0);
      chk("bp_add_a", 32'(bus.add_a), 32'd6);
      chk("bp_add_b", 32'(bus.add_b), 32'd7);
      chk("bp_ready0", 32'(bus.req_ready), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_accept_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_accept_busy", 32'(bus.busy), 32'd0);

    // Reset in EXEC: ptr is 2 now, so a grant to 0 afterwards proves ptr cleared
    bus.req_a[15:12] = 4'd5;
    bus.req_b[15:12] = 4'd5;
    bus.req_valid = 4'b1000;
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready0", 32'(bus.req_ready), 32'd0);
    tick();
    chk_reset_outputs("mid");
    bus.req_valid = '0;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_ptr0", 32'(bus.req_ready), 32'd1);
    bus.req_valid = '0;
    tick();

    // Faulty adder, then sticky err through a correct op, cleared by rst
    fault = 1'b1;
    do_op(0, 4'd3, 4'd4, 4'd8, 1'b0, 1'b1);
    fault = 1'b0;
    do_op(1, 4'd1, 4'd1, 4'd2, 1'b0, 1'b1);
    chk("err_sticky_idle", 32'(bus.err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", 32'(bus.err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that shares one external 4-bit ripple-carry adder (operands `a`, `b`; carry-in `cin`; outputs `sum`, `carry`) among `NUM_REQ` requesters. It accepts operand pairs over a valid/ready handshake and drives the shared adder with registered operands. It captures the 5-bit result and returns it, tagged with the requester ID, over a second valid/ready handshake. It sits between the requesting stimulus/agent blocks and the adder interface, and it owns `cin`, which is held at 0.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID. Derived; do not override.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset; synchronous and active-high.
- `req_valid`, in, `NUM_REQ`: per-requester operand valid.
- `req_a`, in, `4*NUM_REQ`: packed operand A; requester i uses bits `[4i+3:4i]`.
- `req_b`, in, `4*NUM_REQ`: packed operand B, same packing as `req_a`.
- `req_ready`, out, `NUM_REQ`: one-hot grant/accept pulse.
- `add_a`, out, 4: registered operand A driven to the shared adder.
- `add_b`, out, 4: registered operand B driven to the shared adder.
- `add_cin`, out, 1: adder carry-in; always 0.
- `add_sum`, in, 4: adder sum (combinational from `add_a`/`add_b`).
- `add_carry`, in, 1: adder carry-out.
- `rsp_valid`, out, 1: result valid.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_id`, out, `ID_W`: index of the requester that owns the result.
- `rsp_sum`, out, 4: captured sum.
- `rsp_carry`, out, 1: captured carry.
- `busy`, out, 1: high whenever state is not IDLE.
- `err`, out, 1: sticky adder-mismatch flag.

## Operation
The state machine has three states: IDLE, EXEC and RESP.

**IDLE**
- If any `req_valid` bit is set, grant the first set bit found searching from `ptr` upward with wrap-around (`ptr`, `ptr+1`, …, `NUM_REQ-1`, `0`, …).
- `req_ready[winner]` is high for exactly this cycle; the transfer completes here.
- Latch the winner's operands into `add_a`/`add_b`, latch the winner's index into `rsp_id`, then go to EXEC.
- If no `req_valid` bit is set, stay in IDLE and keep all outputs unchanged.

**EXEC**
- The adder settles for one full cycle.
- At the end of the cycle, capture `rsp_sum <= add_sum` and `rsp_carry <= add_carry`, set `rsp_valid`, and go to RESP.
- Check: if `{add_carry, add_sum} != add_a + add_b` (5-bit sum), set `err`. `err` is cleared only by `rst`.

**RESP**
- Hold `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_carry`, `add_a` and `add_b` stable until `rsp_ready` is sampled high.
- On that cycle: clear `rsp_valid`, set `ptr <= (rsp_id+1) mod NUM_REQ`, and go to IDLE.

**Rules**
- No new request is granted in EXEC or RESP. `req_ready` is 0 in those states.
- Requests are not buffered. A requester that drops `req_valid` before being granted loses nothing and is simply not served.
- `add_cin` is constant 0 in every state, including during reset.
- Operands are unsigned 4-bit values. The result is 5 bits: maximum 15+15 = 30 gives `carry=1`, `sum=14`.

## Timing
- Reset values: state=IDLE, `ptr=0`, `req_ready=0`, `add_a=0`, `add_b=0`, `add_cin=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_carry=0`, `busy=0`, `err=0`.
- Latency: grant at cycle T, `rsp_valid` high at T+2 (from the edge ending EXEC).
- Back-to-back throughput with `rsp_ready` held high: one result every 3 cycles (IDLE, EXEC, RESP).
- `rsp_ready` high in the same cycle `rsp_valid` first rises is accepted. IDLE is then entered at T+3 and the next grant can occur at T+3.
- `rst` asserted in any state returns every register to its reset value on the next edge. In-flight operands and results are discarded, and no `rsp_valid` is produced for them.
- `rst` has priority over a simultaneous grant or response acceptance.
- `ptr` wraps from `NUM_REQ-1` to 0. With all requesters valid continuously, grant order is 0, 1, …, `NUM_REQ-1`, 0, ….

## Test plan
1. **Single request.** Reset, then requester 2 presents a=9, b=5 with `rsp_ready=1`. Required: `req_ready=4'b0100` for one cycle; two cycles later `rsp_valid=1`, `rsp_id=2`, `rsp_sum=14`, `rsp_carry=0`; `add_cin=0` throughout.
2. **Overflow.** Requester 0 presents a=15, b=15. Required: `rsp_sum=14`, `rsp_carry=1`, `err=0`.
3. **Fairness.** All 4 requesters hold `req_valid` with distinct operands for 12 responses. Required: `rsp_id` sequence 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3; one response every 3 cycles.
4. **Backpressure.** Hold `rsp_ready=0` for 5 cycles during RESP. Required: `rsp_*`, `add_a` and `add_b` stable; `req_ready=0`; `busy=1`. Acceptance then occurs on the first cycle with `rsp_ready=1`.
5. **Reset mid-op.** Assert `rst` in EXEC. Required: next cycle all outputs at reset values; no response for the dropped operation; `ptr=0`.
6. **Faulty adder.** Force `add_sum` to a+b+1 for a=3, b=4. Required: `rsp_sum=8`, `err=1`, and `err` stays 1 through later correct operations until `rst`.
